// File: rtl/muldiv_unit_if.sv
// Request/write-back bundle between the core and the iterative mul/div unit.
// master: core side (drives the request, sees status and the write port).
// slave : muldiv_unit side.
interface muldiv_unit_if #(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int NUM_OF_SETS    = 32
);
    localparam int AW = $clog2(NUM_OF_SETS);

    logic                      start;
    logic [2:0]                op;
    logic [DATA_BUS_WIDTH-1:0] rs1_data;
    logic [DATA_BUS_WIDTH-1:0] rs2_data;
    logic [AW-1:0]             rd_in;
    logic                      busy;
    logic                      done;
    logic                      wr_enable;
    logic [AW-1:0]             wr_addr;
    logic [DATA_BUS_WIDTH-1:0] wr_data;

    modport master (
        output start, op, rs1_data, rs2_data, rd_in,
        input  busy, done, wr_enable, wr_addr, wr_data
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, rd_in,
        output busy, done, wr_enable, wr_addr, wr_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One radix-2 step per clock on operand
// magnitudes, followed by one sign-correction cycle, then a single-cycle write
// pulse onto the register-file write port. rst is asynchronous, active-low.
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   When defined, divide-by-zero and multiplies with a zero operand skip the
//   iteration and go straight from IDLE to DONE with the same result.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; operands sampled on the accept edge
// CALC  | W shift-add / restoring-divide steps, then sign correction
// DONE  | wr_data valid, done pulses, write strobe unless rd == x0
module muldiv_unit #(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int NUM_OF_SETS    = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int W  = DATA_BUS_WIDTH;
    localparam int AW = $clog2(NUM_OF_SETS);
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q;
    logic [AW-1:0]   addr_q;
    logic [W-1:0]    data_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic [W-1:0]    b_q;
    logic            neg_q;
    logic [CW-1:0]   cnt_q;

    // request decode
    logic            is_div_in;
    logic            a_signed_in, b_signed_in;
    logic            a_sgn_in, b_sgn_in;
    logic            b_zero_in;
    logic            neg_in;
    logic [W-1:0]    a_mag_in, b_mag_in;
    logic            early_in;
    logic [W-1:0]    early_res;

    // iteration datapath
    logic [W:0]      mul_sum;
    logic [W:0]      div_shift;
    logic [W:0]      div_diff;
    logic            div_ok;
    logic [W-1:0]    hi_nx, lo_nx;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix;
    logic [W-1:0]    final_res;

    assign is_div_in   = bus.op[2];
    assign a_signed_in = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                         (bus.op == OP_DIV)  || (bus.op == OP_REM);
    assign b_signed_in = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    assign a_sgn_in    = a_signed_in & bus.rs1_data[W-1];
    assign b_sgn_in    = b_signed_in & bus.rs2_data[W-1];
    assign a_mag_in    = a_sgn_in ? -bus.rs1_data : bus.rs1_data;
    assign b_mag_in    = b_sgn_in ? -bus.rs2_data : bus.rs2_data;
    assign b_zero_in   = (bus.rs2_data == '0);

    // Result sign. A zero divisor keeps the quotient at all ones, so its
    // negation is suppressed; the remainder always follows the dividend.
    always_comb begin
        neg_in = 1'b0;
        case (bus.op)
            OP_MULH:   neg_in = a_sgn_in ^ b_sgn_in;
            OP_MULHSU: neg_in = a_sgn_in;
            OP_DIV:    neg_in = (a_sgn_in ^ b_sgn_in) & ~b_zero_in;
            OP_REM:    neg_in = a_sgn_in;
            default:   neg_in = 1'b0;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic a_zero_in;
    assign a_zero_in = (bus.rs1_data == '0);
    assign early_in  = is_div_in ? b_zero_in : (a_zero_in | b_zero_in);
    assign early_res = is_div_in ? (bus.op[1] ? bus.rs1_data : '1) : '0;
`else
    assign early_in  = 1'b0;
    assign early_res = '0;
`endif

    // Multiply: {hi,lo} is the 2W product; lo starts as the multiplier and
    // shifts out one bit per step while the carry-extended sum shifts in.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

    // Restoring divide: hi is the partial remainder, lo the dividend that
    // turns into the quotient. A borrow shows up in bit W of the difference.
    assign div_shift = {hi_q, lo_q[W-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ok    = ~div_diff[W];

    // Next value of the shared hi/lo pair for the op in flight.
    always_comb begin
        hi_nx = mul_sum[W:1];
        lo_nx = {mul_sum[0], lo_q[W-1:1]};
        if (op_q[2]) begin
            hi_nx = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
            lo_nx = {lo_q[W-2:0], div_ok};
        end
    end

    assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo_fix  = neg_q ? -lo_q : lo_q;
    assign rem_fix  = neg_q ? -hi_q : hi_q;

    // Pick the architectural result once the iteration has finished.
    always_comb begin
        final_res = prod_fix[2*W-1:W];
        if (op_q[2]) begin
            final_res = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q == OP_MUL) begin
            final_res = prod_fix[W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = early_in ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == CW'(W)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, iteration steps and the final registered result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        addr_q <= bus.rd_in;
                        neg_q  <= neg_in;
                        cnt_q  <= '0;
                        hi_q   <= '0;
                        lo_q   <= is_div_in ? a_mag_in : b_mag_in;
                        b_q    <= is_div_in ? b_mag_in : a_mag_in;
                        if (early_in) begin
                            data_q <= early_res;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt_q != CW'(W)) begin
                        hi_q  <= hi_nx;
                        lo_q  <= lo_nx;
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        data_q <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.wr_enable = (state_q == S_DONE) && (addr_q != '0);
    assign bus.wr_addr   = addr_q;
    assign bus.wr_data   = data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: fixed vectors with hand-worked results,
// write timing, busy window, start filtering, mid-op reset and x0 writes.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam int LAT_FULL = W + 1;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_Z = 0;
`else
    localparam int LAT_Z = W + 1;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    muldiv_unit_if #(.DATA_BUS_WIDTH(32), .NUM_OF_SETS(32)) bus ();

    muldiv_unit #(.DATA_BUS_WIDTH(32), .NUM_OF_SETS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op and follow it to its DONE cycle and the IDLE cycle after.
    // With disturb set, extra MUL 3x3 requests are pulsed during CALC and DONE.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat, input bit disturb);
        int lat;
        int busy_pre;
        int we_pre;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.rs1_data = a; bus.rs2_data = b; bus.rd_in = rd;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.op = 3'b000;
        bus.rs1_data = 32'hA5A5_5A5A; bus.rs2_data = 32'h1234_5678; bus.rd_in = 5'd31;
        lat = -1; busy_pre = 0; we_pre = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) busy_pre++;
            if (bus.wr_enable) we_pre++;
            if (disturb) begin
                if (i == 10) begin
                    bus.start = 1'b1; bus.op = 3'b000;
                    bus.rs1_data = 32'd3; bus.rs2_data = 32'd3; bus.rd_in = 5'd7;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_busy_cycles"}, 32'(busy_pre), 32'(exp_lat));
        check_val({tag, "_early_we"}, 32'(we_pre), 32'd0);
        check_val({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
        check_val({tag, "_we"}, {31'd0, bus.wr_enable}, {31'd0, (rd != 5'd0)});
        check_val({tag, "_addr"}, {27'd0, bus.wr_addr}, {27'd0, rd});
        check_val({tag, "_data"}, bus.wr_data, exp);
        if (disturb) begin
            bus.start = 1'b1; bus.op = 3'b000;
            bus.rs1_data = 32'd3; bus.rs2_data = 32'd3; bus.rd_in = 5'd7;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check_val({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check_val({tag, "_we_pulse"}, {31'd0, bus.wr_enable}, 32'd0);
        check_val({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        check_val({tag, "_hold"}, bus.wr_data, exp);
    endtask

    initial begin
        int stray;
        n_checks = 0;
        n_err    = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.op = 3'b000;
        bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_in = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_done", {31'd0, bus.done}, 32'd0);
        check_val("rst_we", {31'd0, bus.wr_enable}, 32'd0);
        check_val("rst_addr", {27'd0, bus.wr_addr}, 32'd0);
        check_val("rst_data", bus.wr_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op("mul_7x6",     3'b000, 32'd7,         32'd6,         5'd5, 32'd42,        LAT_FULL, 1'b0);
        do_op("mulh_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, LAT_FULL, 1'b0);
        do_op("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, LAT_FULL, 1'b0);
        do_op("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'd2,         5'd3, 32'hFFFF_FFFF, LAT_FULL, 1'b0);
        do_op("mul_m1xm1",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, LAT_FULL, 1'b0);
        do_op("mulh_m3x5",   3'b001, 32'hFFFF_FFFD, 32'd5,         5'd6, 32'hFFFF_FFFF, LAT_FULL, 1'b0);

        do_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7, 32'hFFFF_FFFD, LAT_FULL, 1'b0);
        do_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8, 32'hFFFF_FFFF, LAT_FULL, 1'b0);
        do_op("divu_big_2",  3'b101, 32'hFFFF_FFF9, 32'd2,         5'd9, 32'h7FFF_FFFC, LAT_FULL, 1'b0);
        do_op("remu_big_2",  3'b111, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'd1,        LAT_FULL, 1'b0);
        do_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, LAT_FULL, 1'b0);
        do_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,        LAT_FULL, 1'b0);

        do_op("div_5_0",     3'b100, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, LAT_Z, 1'b0);
        do_op("divu_5_0",    3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, LAT_Z, 1'b0);
        do_op("rem_m5_0",    3'b110, 32'hFFFF_FFFB, 32'd0,         5'd15, 32'hFFFF_FFFB, LAT_Z, 1'b0);
        do_op("remu_5_0",    3'b111, 32'd5,         32'd0,         5'd16, 32'd5,        LAT_Z, 1'b0);
        do_op("mul_0xb",     3'b000, 32'd0,         32'h1234,      5'd17, 32'd0,        LAT_Z, 1'b0);
        do_op("mulh_ax0",    3'b001, 32'hFFFF_1234, 32'd0,         5'd18, 32'd0,        LAT_Z, 1'b0);

        do_op("b2b_first",   3'b000, 32'd7,         32'd6,         5'd5, 32'd42,        LAT_FULL, 1'b1);
        do_op("b2b_next",    3'b000, 32'd3,         32'd3,         5'd7, 32'd9,         LAT_FULL, 1'b0);

        // Reset in the middle of DIV 100/7 must abort without any write.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b100; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.rd_in = 5'd20;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check_val("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        #1;
        check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_val("abort_done", {31'd0, bus.done}, 32'd0);
        check_val("abort_we", {31'd0, bus.wr_enable}, 32'd0);
        check_val("abort_data", bus.wr_data, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wr_enable || bus.done || bus.busy) stray++;
        end
        check_val("abort_no_write", 32'(stray), 32'd0);

        do_op("div_100_7",   3'b100, 32'd100, 32'd7, 5'd21, 32'd14, LAT_FULL, 1'b0);
        do_op("rem_100_7",   3'b110, 32'd100, 32'd7, 5'd22, 32'd2,  LAT_FULL, 1'b0);
        do_op("divu_x0",     3'b101, 32'd100, 32'd7, 5'd0,  32'd14, LAT_FULL, 1'b0);
        do_op("mul_x0",      3'b000, 32'd9,   32'd9, 5'd0,  32'd81, LAT_FULL, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
